stream_stats: RTL



---
 rtl/stream_stats.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stream_stats.sv
// ==========================================================================
// stream_stats - per-burst max/min/first-index (and optional sum) tracker
// Optional macro STATS_SUM_EN builds the burst-sum path; else out_sum is 0
// Revision: 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module stream_stats #(
  parameter int WIDTH  = 8,
  parameter int LEN    = 15,
  parameter int SIGNED = 0,
  localparam int IW    = $clog2(LEN),
  localparam int SW    = WIDTH + $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IW-1:0]    out_imax,
  output logic [IW-1:0]    out_imin,
  output logic [SW-1:0]    out_sum
);

  localparam logic [IW-1:0] c_last_idx = IW'(LEN - 1);

  logic [IW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [IW-1:0]    r_imax;
  logic [IW-1:0]    r_imin;

  logic             w_first;
  logic             w_last;
  logic             w_gt;
  logic             w_lt;
  logic [WIDTH-1:0] w_max_nxt;
  logic [WIDTH-1:0] w_min_nxt;
  logic [IW-1:0]    w_imax_nxt;
  logic [IW-1:0]    w_imin_nxt;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == c_last_idx);

  // Strict compares keep the earliest index on ties
  assign w_gt = (SIGNED != 0) ? ($signed(in_num) > $signed(r_max)) : (in_num > r_max);
  assign w_lt = (SIGNED != 0) ? ($signed(in_num) < $signed(r_min)) : (in_num < r_min);

  always_comb begin
    w_max_nxt  = r_max;
    w_min_nxt  = r_min;
    w_imax_nxt = r_imax;
    w_imin_nxt = r_imin;
    if (w_first) begin
      w_max_nxt  = in_num;
      w_min_nxt  = in_num;
      w_imax_nxt = '0;
      w_imin_nxt = '0;
    end else begin
      if (w_gt) begin
        w_max_nxt  = in_num;
        w_imax_nxt = r_cnt;
      end
      if (w_lt) begin
        w_min_nxt  = in_num;
        w_imin_nxt = r_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_imax    <= '0;
      r_imin    <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_min   <= '0;
      out_imax  <= '0;
      out_imin  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        r_max  <= w_max_nxt;
        r_min  <= w_min_nxt;
        r_imax <= w_imax_nxt;
        r_imin <= w_imin_nxt;
        if (w_last) begin
          r_cnt     <= '0;
          out_valid <= 1'b1;
          out_max   <= w_max_nxt;
          out_min   <= w_min_nxt;
          out_imax  <= w_imax_nxt;
          out_imin  <= w_imin_nxt;
        end else begin
          r_cnt <= r_cnt + IW'(1);
        end
      end else begin
        // A gap mid-burst abandons the partial burst; results stay held
        r_cnt <= '0;
      end
    end
  end

`ifdef STATS_SUM_EN
  logic [SW-1:0] w_ext;
  logic [SW-1:0] w_sum_nxt;
  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_out_sum;

  assign w_ext = (SIGNED != 0) ? {{(SW-WIDTH){in_num[WIDTH-1]}}, in_num}
                               : {{(SW-WIDTH){1'b0}}, in_num};
  assign w_sum_nxt = w_first ? w_ext : (r_sum + w_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_out_sum <= '0;
    end else if (in_valid) begin
      r_sum <= w_sum_nxt;
      if (w_last) begin
        r_out_sum <= w_sum_nxt;
      end
    end
  end

  assign out_sum = r_out_sum;
`else
  assign out_sum = '0;
`endif

endmodule

`default_nettype wire
